// File: rtl/fp_addsub_align_stage_pkg.sv
// Shared definitions for the FP add/sub alignment stage.
// Provides the `EXPONENT / `MANTISSA / `DWIDTH format defines (overridable
// on the command line), the guard/round/sticky width, and the bit positions
// of the InputExc exception vector.
// Optional feature macro used by this slice: FPADDSUB_ALIGN_STICKY_EN.
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef DWIDTH
`define DWIDTH (`EXPONENT + `MANTISSA)
`endif

package fp_addsub_align_stage_pkg;
  localparam int EXP_W  = `EXPONENT;
  localparam int MAN_W  = `MANTISSA;
  localparam int DATA_W = `DWIDTH;
  localparam int GRS_W  = 3;
  localparam int EXC_W  = 5;

  // InputExc bit positions
  localparam int EXC_ANY  = 0;
  localparam int EXC_ANAN = 1;
  localparam int EXC_BNAN = 2;
  localparam int EXC_AINF = 3;
  localparam int EXC_BINF = 4;
endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right shifter for the smaller operand's extended mantissa.
//   ext   : {hidden, mantissa, G, R, S} before alignment
//   shamt : right-shift distance (may exceed the vector width)
//   mmin  : aligned value
// With FPADDSUB_ALIGN_STICKY_EN defined, bit 0 also collects the OR of every
// bit pushed below it, including when the whole vector is shifted away.
// Without it, shifted-out bits are simply discarded (truncation).
module fp_align_shifter #(
  parameter int W   = 14,
  parameter int SHW = 5
) (
  input  logic [W-1:0]   ext,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   mmin
);

`ifdef FPADDSUB_ALIGN_STICKY_EN
  logic [W-1:0] shifted;
  logic         lost;

  always_comb begin
    shifted = ext >> shamt;
    lost    = 1'b0;
    // Bit i is lost exactly when it sits below the shift distance.
    for (int i = 0; i < W; i++) begin
      if (i < int'(shamt)) lost = lost | ext[i];
    end
    mmin = {shifted[W-1:1], shifted[0] | lost};
  end
`else
  always_comb begin
    mmin = ext >> shamt;
  end
`endif

endmodule

// File: rtl/fp_addsub_align_stage.sv
// Elastic two-stage alignment pipeline for the FP adder/subtractor.
// Stage 1 picks the larger-exponent operand, restores hidden bits and fixes
// the shift distance for denormals; stage 2 right-shifts the smaller mantissa
// into G/R/S positions. Valid/ready on both sides, latency 2, full throughput.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, Sa, Sb, ShiftDet {B-A, A-B}, InputExc, Aout, Bout, Opout
//   out_valid/out_ready, Smax, Smin, Emax, Mmax, Mmin, Swap, OpOut, ExcOut
// Optional feature macro: FPADDSUB_ALIGN_STICKY_EN (sticky collection in Mmin[0]).
module fp_addsub_align_stage
  import fp_addsub_align_stage_pkg::*;
#(
  parameter int EW  = EXP_W,
  parameter int MW  = MAN_W,
  parameter int SHW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               Sa,
  input  logic               Sb,
  input  logic [2*SHW-1:0]   ShiftDet,
  input  logic [EXC_W-1:0]   InputExc,
  input  logic [EW+MW-1:0]   Aout,
  input  logic [EW+MW-1:0]   Bout,
  input  logic               Opout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               Smax,
  output logic               Smin,
  output logic [EW-1:0]      Emax,
  output logic [MW:0]        Mmax,
  output logic [MW+3:0]      Mmin,
  output logic               Swap,
  output logic               OpOut,
  output logic [EXC_W-1:0]   ExcOut
);

  localparam int XW = MW + 1 + GRS_W;

  logic [EW-1:0]    exp_a, exp_b, emax_c, emin_c;
  logic [MW-1:0]    man_max, man_min;
  logic             swap_c, smax_c, smin_c;
  logic [SHW-1:0]   shamt_c;
  logic [MW:0]      mmax_c;
  logic [XW-1:0]    ext_c;

  logic             vld_p1, swap_p1, smax_p1, smin_p1, op_p1;
  logic [EW-1:0]    emax_p1;
  logic [MW:0]      mmax_p1;
  logic [XW-1:0]    ext_p1;
  logic [SHW-1:0]   shamt_p1;
  logic [EXC_W-1:0] exc_p1;

  logic             vld_p2, s2_rdy;
  logic [XW-1:0]    mmin_c;

  assign s2_rdy    = ~vld_p2 | out_ready;
  assign in_ready  = ~vld_p1 | s2_rdy;
  assign out_valid = vld_p2;

  always_comb begin
    exp_a   = Aout[EW+MW-1:MW];
    exp_b   = Bout[EW+MW-1:MW];
    // Equal exponents keep A as the larger operand.
    swap_c  = (exp_a < exp_b);
    emax_c  = swap_c ? exp_b : exp_a;
    emin_c  = swap_c ? exp_a : exp_b;
    man_max = swap_c ? Bout[MW-1:0] : Aout[MW-1:0];
    man_min = swap_c ? Aout[MW-1:0] : Bout[MW-1:0];
    smax_c  = swap_c ? Sb : Sa;
    smin_c  = swap_c ? Sa : Sb;
    shamt_c = swap_c ? ShiftDet[2*SHW-1:SHW] : ShiftDet[SHW-1:0];
    // A denormal has an effective exponent of 1, not 0.
    if ((emin_c == '0) && (emax_c != '0)) shamt_c = shamt_c - SHW'(1);
    mmax_c  = {|emax_c, man_max};
    ext_c   = {|emin_c, man_min, {GRS_W{1'b0}}};
  end

  // ---- stage 1: operand selection ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      swap_p1  <= 1'b0;
      smax_p1  <= 1'b0;
      smin_p1  <= 1'b0;
      op_p1    <= 1'b0;
      emax_p1  <= '0;
      mmax_p1  <= '0;
      ext_p1   <= '0;
      shamt_p1 <= '0;
      exc_p1   <= '0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        swap_p1  <= swap_c;
        smax_p1  <= smax_c;
        smin_p1  <= smin_c;
        op_p1    <= Opout;
        emax_p1  <= emax_c;
        mmax_p1  <= mmax_c;
        ext_p1   <= ext_c;
        shamt_p1 <= shamt_c;
        exc_p1   <= InputExc;
      end
    end
  end

  fp_align_shifter #(.W(XW), .SHW(SHW)) u_shift (
    .ext   (ext_p1),
    .shamt (shamt_p1),
    .mmin  (mmin_c)
  );

  // ---- stage 2: aligned output registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2 <= 1'b0;
      Swap   <= 1'b0;
      Smax   <= 1'b0;
      Smin   <= 1'b0;
      OpOut  <= 1'b0;
      Emax   <= '0;
      Mmax   <= '0;
      Mmin   <= '0;
      ExcOut <= '0;
    end else if (s2_rdy) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        Swap   <= swap_p1;
        Smax   <= smax_p1;
        Smin   <= smin_p1;
        OpOut  <= op_p1;
        Emax   <= emax_p1;
        Mmax   <= mmax_p1;
        Mmin   <= mmin_c;
        ExcOut <= exc_p1;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_align_stage.sv
// Self-checking bench for fp_addsub_align_stage (half-precision defaults).
module tb_fp_addsub_align_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, Sa, Sb, Opout;
  logic [9:0]  ShiftDet;
  logic [4:0]  InputExc;
  logic [14:0] Aout, Bout;
  logic        out_valid, out_ready;
  logic        Smax, Smin, Swap, OpOut;
  logic [4:0]  Emax, ExcOut;
  logic [10:0] Mmax;
  logic [13:0] Mmin;

  always #5 clk = ~clk;

  fp_addsub_align_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sa(Sa), .Sb(Sb), .ShiftDet(ShiftDet), .InputExc(InputExc),
    .Aout(Aout), .Bout(Bout), .Opout(Opout),
    .out_valid(out_valid), .out_ready(out_ready),
    .Smax(Smax), .Smin(Smin), .Emax(Emax), .Mmax(Mmax), .Mmin(Mmin),
    .Swap(Swap), .OpOut(OpOut), .ExcOut(ExcOut)
  );

  typedef struct packed {
    logic        swap;
    logic [4:0]  emax;
    logic [10:0] mmax;
    logic [13:0] mmin;
    logic        smax;
    logic        smin;
    logic        op;
    logic [4:0]  exc;
  } res_t;

  typedef struct {
    logic [14:0] a;
    logic [14:0] b;
    logic        sa;
    logic        sb;
    logic        op;
    logic [4:0]  exc;
    res_t        exp;
  } vec_t;

`ifdef FPADDSUB_ALIGN_STICKY_EN
  localparam logic [13:0] STK = 14'd1;
  localparam bit STICKY = 1'b1;
`else
  localparam logic [13:0] STK = 14'd0;
  localparam bit STICKY = 1'b0;
`endif

  localparam int NT = 10;
  vec_t tbl [NT];
  res_t q[$];
  res_t dut_res;
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   accepted  = 0;
  bit   rnd_done  = 1'b0;

  assign dut_res = {Swap, Emax, Mmax, Mmin, Smax, Smin, OpOut, ExcOut};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  function automatic vec_t mk(input logic [14:0] a, b, input logic sa, sb, op, input logic [4:0] exc,
                              input logic swap, input logic [4:0] emax, input logic [10:0] mmax,
                              input logic [13:0] mmin, input logic smax, smin);
    vec_t v;
    v.a = a; v.b = b; v.sa = sa; v.sb = sb; v.op = op; v.exc = exc;
    v.exp = {swap, emax, mmax, mmin, smax, smin, op, exc};
    return v;
  endfunction

  // Reference alignment computed from the true exponent difference.
  function automatic res_t model(input logic [14:0] a, b, input logic sa, sb, op, input logic [4:0] exc);
    res_t r;
    int ea, eb, emx, emn, d;
    logic [9:0] mx, mn;
    longint ext, sh;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    r.swap = (ea < eb);
    if (r.swap) begin
      emx = eb; emn = ea; mx = b[9:0]; mn = a[9:0]; r.smax = sb; r.smin = sa;
    end else begin
      emx = ea; emn = eb; mx = a[9:0]; mn = b[9:0]; r.smax = sa; r.smin = sb;
    end
    d = emx - emn;
    if (emn == 0 && emx != 0) d = d - 1;
    ext = ((emn != 0) ? 64'sd8192 : 64'sd0) + (longint'(mn) * 8);
    sh  = (d >= 14) ? 64'sd0 : (ext >>> d);
    if (STICKY && ((ext & ((64'sd1 <<< d) - 1)) != 0)) sh = sh | 64'sd1;
    r.emax = 5'(emx);
    r.mmax = {emx != 0, mx};
    r.mmin = 14'(sh);
    r.op   = op;
    r.exc  = exc;
    return r;
  endfunction

  task automatic send(input vec_t v);
    logic [4:0] dab, dba;
    dab = v.a[14:10] - v.b[14:10];
    dba = v.b[14:10] - v.a[14:10];
    Aout = v.a; Bout = v.b; Sa = v.sa; Sb = v.sb; Opout = v.op; InputExc = v.exc;
    ShiftDet = {dba, dab};
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(v.exp);
        accepted++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check_cnt++;
    $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  // Scoreboard: compare on transfer, and check held data during stalls.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_output: got %0h, expected none", dut_res);
      end else if (out_ready) begin
        chk("result", 64'(dut_res), 64'(q.pop_front()));
      end else begin
        chk("held_result", 64'(dut_res), 64'(q[0]));
      end
    end
  end

  initial begin
    int lat;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Sa = 1'b0; Sb = 1'b0; Opout = 1'b0; ShiftDet = '0; InputExc = '0; Aout = '0; Bout = '0;

    //             a        b        sa sb op exc    swap emax mmax    mmin         smax smin
    tbl[0] = mk(15'h3C00, 15'h3800, 0, 0, 0, 5'h00, 0, 5'd15, 11'h400, 14'h1000,      0, 0);
    tbl[1] = mk(15'h3800, 15'h3C00, 0, 1, 1, 5'h00, 1, 5'd15, 11'h400, 14'h1000,      1, 0);
    tbl[2] = mk(15'h7800, 15'h3C01, 1, 0, 0, 5'h00, 0, 5'd30, 11'h400, STK,           1, 0);
    tbl[3] = mk(15'h0400, 15'h0001, 0, 0, 0, 5'h00, 0, 5'd1,  11'h400, 14'h0008,      0, 0);
    tbl[4] = mk(15'h7BFF, 15'h0001, 0, 1, 1, 5'h00, 0, 5'd30, 11'h7FF, STK,           0, 1);
    tbl[5] = mk(15'h4000, 15'h4200, 0, 1, 0, 5'h00, 0, 5'd16, 11'h400, 14'h3000,      0, 1);
    tbl[6] = mk(15'h7C01, 15'h3C00, 0, 0, 0, 5'h03, 0, 5'd31, 11'h401, STK,           0, 0);
    tbl[7] = mk(15'h0003, 15'h0005, 1, 1, 0, 5'h10, 0, 5'd0,  11'h003, 14'h0028,      1, 1);
    tbl[8] = mk(15'h3800, 15'h0400, 0, 0, 1, 5'h00, 0, 5'd14, 11'h400, 14'h0001,      0, 0);
    tbl[9] = mk(15'h0401, 15'h3400, 0, 1, 0, 5'h0C, 1, 5'd13, 11'h400, 14'h0002|STK, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(dut_res), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back to back.
    for (int i = 0; i < NT; i++) send(tbl[i]);
    drain();

    // Backpressure: four inputs offered while the output is stalled.
    accepted = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_accepted", 64'(accepted), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random output stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          vec_t v;
          logic [4:0] ea, eb;
          ea = 5'($urandom_range(0, 31));
          if ($urandom_range(0, 1) == 1) eb = 5'($urandom_range(0, 31));
          else eb = ea + 5'($urandom_range(0, 3));
          v.a   = {ea, 10'($urandom)};
          v.b   = {eb, 10'($urandom)};
          v.sa  = 1'($urandom);
          v.sb  = 1'($urandom);
          v.op  = 1'($urandom);
          v.exc = 5'($urandom);
          v.exp = model(v.a, v.b, v.sa, v.sb, v.op, v.exc);
          send(v);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with both stages occupied, then post-reset latency.
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outputs", 64'(dut_res), 64'd0);
    q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(tbl[2]);
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("post_reset_latency", 64'(lat), 64'd2);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
